nibble_serial_tx: RTL and testbench

Transmit stage that sits directly downstream of the 4-bit shift register. It accepts one 4-bit parallel word per valid/ready handshake. Each word goes out on a single serial line as an asynchronous-style frame: start bit, 4 data bits LSB first, and a stop bit, with an optional even-parity bit. Bit duration is set by a clock-divider parameter, so the register contents can be observed off-chip on one pin.

---
 rtl/nibble_serial_tx.sv | 157 +++++++++++++++
 tb/tb_nibble_serial_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_tx.sv
// ============================================================================
//  Module      : nibble_serial_tx
//  Description : Serialises one 4-bit word per valid/ready handshake as a
//                frame on a single line: start bit (0), data LSB first,
//                optional even-parity bit, stop bit (1). Each bit lasts
//                CLKS_PER_BIT clock cycles.
//                Optional feature macro: NIBBLE_TX_PARITY_EN (adds the
//                even-parity bit between the last data bit and the stop bit).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_tx #(
  parameter int CLKS_PER_BIT = 4  // legal range 1..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx_serial,
  output logic       busy,
  output logic [7:0] frame_count
);

  // Divider only has to reach CLKS_PER_BIT-1; keep at least one bit so that
  // CLKS_PER_BIT=1 still yields a legal vector.
  localparam int DIV_W_RAW = $clog2(CLKS_PER_BIT + 1);
  localparam int DIV_W     = (DIV_W_RAW < 1) ? 1 : DIV_W_RAW;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

`ifdef NIBBLE_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       bit_idx;
  logic [3:0]       held;

  logic             bit_done;
  logic [1:0]       next_idx;

  // The current bit period ends on this cycle's edge.
  assign bit_done = (div_cnt == DIV_LAST);
  assign next_idx = bit_idx + 2'd1;

  // Frame sequencer: every output is produced here so nothing on the pins is
  // combinationally derived from data_in or data_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div_cnt     <= '0;
      bit_idx     <= 2'd0;
      held        <= 4'd0;
      tx_serial   <= 1'b1;
      data_ready  <= 1'b1;
      busy        <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          tx_serial <= 1'b1;
          if (data_valid && data_ready) begin
            held       <= data_in;
            state      <= START;
            data_ready <= 1'b0;
            busy       <= 1'b1;
            tx_serial  <= 1'b0;   // start bit appears on the accepting edge
            div_cnt    <= '0;
            bit_idx    <= 2'd0;
          end
        end

        START: begin
          if (bit_done) begin
            div_cnt   <= '0;
            state     <= DATA;
            tx_serial <= held[0];
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        DATA: begin
          if (bit_done) begin
            div_cnt <= '0;
            if (bit_idx == 2'd3) begin
`ifdef NIBBLE_TX_PARITY_EN
              state     <= PARITY;
              tx_serial <= ^held;
`else
              state     <= STOP;
              tx_serial <= 1'b1;
`endif
            end else begin
              bit_idx   <= next_idx;
              tx_serial <= held[next_idx];
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

`ifdef NIBBLE_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            div_cnt   <= '0;
            state     <= STOP;
            tx_serial <= 1'b1;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
`endif

        STOP: begin
          if (bit_done) begin
            div_cnt     <= '0;
            state       <= IDLE;
            busy        <= 1'b0;
            data_ready  <= 1'b1;
            frame_count <= frame_count + 8'd1;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: begin
          // Unreachable encodings recover to a clean idle line.
          state      <= IDLE;
          div_cnt    <= '0;
          bit_idx    <= 2'd0;
          tx_serial  <= 1'b1;
          data_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_tx.sv
// ============================================================================
//  Module      : tb_nibble_serial_tx
//  Description : Self-checking bench for nibble_serial_tx. Two instances:
//                dut_a at CLKS_PER_BIT=4 and dut_b at CLKS_PER_BIT=1.
//                Honours NIBBLE_TX_PARITY_EN for the expected frame shape.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nibble_serial_tx;

`ifdef NIBBLE_TX_PARITY_EN
  localparam int F = 7;
`else
  localparam int F = 6;
`endif
  localparam int CPB_A = 4;
  localparam int CPB_B = 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] data_a = 4'd0, data_b = 4'd0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       ready_a, tx_a, busy_a;
  logic       ready_b, tx_b, busy_b;
  logic [7:0] count_a, count_b;

  int errors = 0;
  int checks = 0;
  int exp_count_a = 0;
  int exp_count_b = 0;

  always #5 clk = ~clk;

  nibble_serial_tx #(.CLKS_PER_BIT(CPB_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(data_a), .data_valid(valid_a),
    .data_ready(ready_a), .tx_serial(tx_a), .busy(busy_a), .frame_count(count_a)
  );

  nibble_serial_tx #(.CLKS_PER_BIT(CPB_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(data_b), .data_valid(valid_b),
    .data_ready(ready_b), .tx_serial(tx_b), .busy(busy_b), .frame_count(count_b)
  );

  // Reference frame: bit position 0 is start, 1..4 data LSB first,
  // then optional even parity, and the last position is the stop bit.
  function automatic logic exp_bit(input logic [3:0] d, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 4) return d[pos-1];
`ifdef NIBBLE_TX_PARITY_EN
    if (pos == 5) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst_n   = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_count_a = 0;
    exp_count_b = 0;
    for (int c = 0; c < 11; c++) begin
      checks++;
      if (tx_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0 || count_a !== 8'd0) begin
        errors++;
        $display("FAIL reset_a cycle %0d: got tx=%b ready=%b busy=%b count=%0d, required tx=1 ready=1 busy=0 count=0",
                 c, tx_a, ready_a, busy_a, count_a);
      end
      checks++;
      if (tx_b !== 1'b1 || ready_b !== 1'b1 || busy_b !== 1'b0 || count_b !== 8'd0) begin
        errors++;
        $display("FAIL reset_b cycle %0d: got tx=%b ready=%b busy=%b count=%0d, required tx=1 ready=1 busy=0 count=0",
                 c, tx_b, ready_b, busy_b, count_b);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] d;
    int         c_rst;
    d     = 4'($urandom_range(0, 15)) & 4'b1011;  // bit 2 low so the line visibly rises
    c_rst = 3 * CPB_A + int'($urandom_range(0, CPB_A - 1));
    data_a  = d;
    valid_a = 1'b1;
    for (int c = 0; c <= c_rst; c++) begin
      @(negedge clk);
      if (c == 0) valid_a = 1'b0;
      checks++;
      if (tx_a !== exp_bit(d, c / CPB_A) || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL pre_reset_frame cycle %0d: got tx=%b busy=%b, required tx=%b busy=1",
                 c, tx_a, busy_a, exp_bit(d, c / CPB_A));
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || ready_a !== 1'b1 || count_a !== 8'(exp_count_a)) begin
      errors++;
      $display("FAIL async_reset: got tx=%b busy=%b ready=%b count=%0d, required tx=1 busy=0 ready=1 count=%0d",
               tx_a, busy_a, ready_a, count_a, exp_count_a);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || count_a !== 8'(exp_count_a)) begin
      errors++;
      $display("FAIL after_reset_release: got tx=%b busy=%b count=%0d, required tx=1 busy=0 count=%0d",
               tx_a, busy_a, count_a, exp_count_a);
    end
  endtask

  task automatic test_frames(input int n);
    logic [3:0] d;
    int         gap;
    int         busy_cycles;
    for (int f = 0; f < n; f++) begin
      d   = (f == 0) ? 4'b1010 : (f == 1) ? 4'b0111 : 4'($urandom_range(0, 15));
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        valid_a = 1'b0;
        data_a  = 4'($urandom_range(0, 15));
        @(negedge clk);
        checks++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || ready_a !== 1'b1 || count_a !== 8'(exp_count_a)) begin
          errors++;
          $display("FAIL idle_gap frame %0d: got tx=%b busy=%b ready=%b count=%0d, required tx=1 busy=0 ready=1 count=%0d",
                   f, tx_a, busy_a, ready_a, count_a, exp_count_a);
        end
      end
      data_a      = d;
      valid_a     = 1'b1;
      busy_cycles = 0;
      for (int c = 0; c < F * CPB_A; c++) begin
        @(negedge clk);
        if (c == 0) begin
          valid_a = 1'b0;
          data_a  = ~d;
        end
        if (busy_a === 1'b1) busy_cycles++;
        checks++;
        if (tx_a !== exp_bit(d, c / CPB_A) || ready_a !== 1'b0) begin
          errors++;
          $display("FAIL frame_bits data=%h cycle %0d: got tx=%b ready=%b, required tx=%b ready=0",
                   d, c, tx_a, ready_a, exp_bit(d, c / CPB_A));
        end
      end
      @(negedge clk);
      exp_count_a = (exp_count_a + 1) % 256;
      checks++;
      if (busy_cycles != F * CPB_A || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL busy_length data=%h: got %0d busy cycles (busy now %b), required %0d then low",
                 d, busy_cycles, busy_a, F * CPB_A);
      end
      checks++;
      if (tx_a !== 1'b1 || ready_a !== 1'b1 || count_a !== 8'(exp_count_a)) begin
        errors++;
        $display("FAIL frame_end data=%h: got tx=%b ready=%b count=%0d, required tx=1 ready=1 count=%0d",
                 d, tx_a, ready_a, count_a, exp_count_a);
      end
    end
  endtask

  task automatic test_back_to_back();
    data_a  = 4'h3;
    valid_a = 1'b1;
    for (int c = 0; c < F * CPB_A; c++) begin
      @(negedge clk);
      data_a = 4'($urandom_range(0, 15));
      checks++;
      if (tx_a !== exp_bit(4'h3, c / CPB_A) || busy_a !== 1'b1 || ready_a !== 1'b0) begin
        errors++;
        $display("FAIL b2b_first cycle %0d: got tx=%b busy=%b ready=%b, required tx=%b busy=1 ready=0",
                 c, tx_a, busy_a, ready_a, exp_bit(4'h3, c / CPB_A));
      end
    end
    @(negedge clk);
    exp_count_a = (exp_count_a + 1) % 256;
    checks++;
    if (ready_a !== 1'b1 || busy_a !== 1'b0 || count_a !== 8'(exp_count_a)) begin
      errors++;
      $display("FAIL b2b_second_accept: got ready=%b busy=%b count=%0d, required ready=1 busy=0 count=%0d at cycle %0d",
               ready_a, busy_a, count_a, exp_count_a, F * CPB_A + 1);
    end
    data_a = 4'hC;
    for (int c = 0; c < F * CPB_A; c++) begin
      @(negedge clk);
      if (c == 0) valid_a = 1'b0;
      data_a = 4'($urandom_range(0, 15));
      checks++;
      if (tx_a !== exp_bit(4'hC, c / CPB_A) || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL b2b_second cycle %0d: got tx=%b busy=%b, required tx=%b busy=1",
                 c, tx_a, busy_a, exp_bit(4'hC, c / CPB_A));
      end
    end
    @(negedge clk);
    exp_count_a = (exp_count_a + 1) % 256;
    checks++;
    if (busy_a !== 1'b0 || ready_a !== 1'b1 || count_a !== 8'(exp_count_a)) begin
      errors++;
      $display("FAIL b2b_end: got busy=%b ready=%b count=%0d, required busy=0 ready=1 count=%0d",
               busy_a, ready_a, count_a, exp_count_a);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] d;
    d       = 4'($urandom_range(0, 15));
    data_b  = d;
    valid_b = 1'b1;
    for (int f = 0; f < 256; f++) begin
      for (int c = 0; c < F * CPB_B; c++) begin
        @(negedge clk);
        data_b = 4'($urandom_range(0, 15));
        checks++;
        if (tx_b !== exp_bit(d, c / CPB_B) || busy_b !== 1'b1) begin
          errors++;
          $display("FAIL wrap_bits frame %0d cycle %0d: got tx=%b busy=%b, required tx=%b busy=1",
                   f, c, tx_b, busy_b, exp_bit(d, c / CPB_B));
        end
      end
      @(negedge clk);
      exp_count_b = (exp_count_b + 1) % 256;
      checks++;
      if (busy_b !== 1'b0 || ready_b !== 1'b1 || count_b !== 8'(exp_count_b)) begin
        errors++;
        $display("FAIL wrap_end frame %0d: got busy=%b ready=%b count=%0d, required busy=0 ready=1 count=%0d",
                 f, busy_b, ready_b, count_b, exp_count_b);
      end
      d      = 4'($urandom_range(0, 15));
      data_b = d;
    end
    valid_b = 1'b0;
    @(negedge clk);
    checks++;
    if (count_b !== 8'd0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL wrap_count: got count=%0d busy=%b, required count=0 busy=0", count_b, busy_b);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_frames(8);
    test_back_to_back();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire
